// File: rtl/chunked_seq_adder.sv
// ============================================================================
// Module      : chunked_seq_adder
// Description : Multi-cycle WIDTH-bit adder/subtractor. One CHUNK-bit slice
//               is summed per clock, least significant slice first, with the
//               inter-slice carry held in a register. Operands enter through a
//               valid/ready handshake and the result is held until accepted.
//               Optional zero flag output Z: define CHUNKED_SEQ_ADDER_ZERO_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module chunked_seq_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:WIDTH-1] A,
   input  logic [0:WIDTH-1] B,
   input  logic             Ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:WIDTH-1] S,
   output logic             Co,
   output logic             ovf
`ifdef CHUNKED_SEQ_ADDER_ZERO_EN
   ,
   output logic             Z
`endif
);

   localparam int c_nchunk = WIDTH / CHUNK;
   localparam int c_cw     = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(c_nchunk - 1);

   // Reject geometries where the operand does not split into whole slices.
   generate
      if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_geometry
         $error("chunked_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [0:WIDTH-1]  r_a;
   logic [0:WIDTH-1]  r_b;        // already inverted for subtraction
   logic              r_c;        // carry between slices
   logic [c_cw-1:0]   r_cnt;      // slice index, 0 = least significant
   logic [0:WIDTH-1]  r_s;
   logic              r_co;
   logic              r_ovf;

   logic [CHUNK-1:0]  w_a_sl;
   logic [CHUNK-1:0]  w_b_sl;
   logic [CHUNK:0]    w_sum;
   logic              w_c_msb;    // carry into the top bit of this slice
   logic              w_last;

`ifdef CHUNKED_SEQ_ADDER_ZERO_EN
   logic              r_zacc;     // all slices so far summed to zero
   logic              r_z;
`endif

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign S         = r_s;
   assign Co        = r_co;
   assign ovf       = r_ovf;
`ifdef CHUNKED_SEQ_ADDER_ZERO_EN
   assign Z         = r_z;
`endif

   // Select the current slice of both operands (bit 0 is the MSB, so slice k
   // starts at WIDTH-CHUNK*(k+1)).
   always_comb begin
      w_a_sl = '0;
      w_b_sl = '0;
      for (int k = 0; k < c_nchunk; k++) begin
         if (r_cnt == c_cw'(k)) begin
            w_a_sl = r_a[WIDTH-CHUNK*(k+1) +: CHUNK];
            w_b_sl = r_b[WIDTH-CHUNK*(k+1) +: CHUNK];
         end
      end
   end

   // Slice adder; the MSB carry-in is recovered from the sum bit.
   assign w_sum   = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_c};
   assign w_c_msb = w_sum[CHUNK-1] ^ w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1];
   assign w_last  = (r_cnt == c_last);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_next = RUN;
         RUN:     if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand capture and slice-by-slice accumulation of the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_s    <= '0;
         r_co   <= 1'b0;
         r_ovf  <= 1'b0;
`ifdef CHUNKED_SEQ_ADDER_ZERO_EN
         r_zacc <= 1'b0;
         r_z    <= 1'b0;
`endif
      end else begin
         if ((r_state == IDLE) && in_valid) begin
            r_a    <= A;
            r_b    <= B ^ {WIDTH{sub}};
            r_c    <= Ci ^ sub;
            r_cnt  <= '0;
`ifdef CHUNKED_SEQ_ADDER_ZERO_EN
            r_zacc <= 1'b1;
`endif
         end else if (r_state == RUN) begin
            r_c   <= w_sum[CHUNK];
            r_cnt <= r_cnt + c_cw'(1);
            for (int k = 0; k < c_nchunk; k++) begin
               if (r_cnt == c_cw'(k)) begin
                  r_s[WIDTH-CHUNK*(k+1) +: CHUNK] <= w_sum[CHUNK-1:0];
               end
            end
`ifdef CHUNKED_SEQ_ADDER_ZERO_EN
            r_zacc <= r_zacc & (w_sum[CHUNK-1:0] == '0);
`endif
            if (w_last) begin
               r_co  <= w_sum[CHUNK];
               r_ovf <= w_c_msb ^ w_sum[CHUNK];
`ifdef CHUNKED_SEQ_ADDER_ZERO_EN
               r_z   <= r_zacc & (w_sum[CHUNK-1:0] == '0);
`endif
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/chunked_seq_adder.md
Name: chunked_seq_adder

Overview:
Parametrised multi-cycle adder/subtractor, successor to the fixed 8-bit two-slice adder. It processes WIDTH-bit operands one CHUNK-bit slice per clock, holding the inter-slice carry in a register. Operands enter and results leave through valid/ready handshakes. It sits in the datapath wherever a narrow, area-cheap adder with configurable width is needed.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise).
CHUNK, 4, bits summed per clock; NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept an operation
A  input  [0:WIDTH-1]  operand A; bit 0 = MSB
B  input  [0:WIDTH-1]  operand B; bit 0 = MSB
Ci  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
S  output  [0:WIDTH-1]  sum/difference; bit 0 = MSB
Co  output  1  carry-out (add) / NOT borrow-out (sub)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Arithmetic:
  - sub=0: {Co,S} = A + B + Ci.
  - sub=1: {Co,S} = A + ~B + !Ci, i.e. S = A - B - Ci; Co=0 means a borrow occurred.
  - ovf = carry into the MSB XOR Co.
- FSM states IDLE, RUN, DONE.
- Reset (async assert, sync release):
  - State IDLE; chunk counter, carry register, S, Co, ovf and out_valid all 0.
  - in_ready = (state==IDLE) is combinational. No capture occurs while rst_n is low.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch A, B^{WIDTH{sub}} and the initial carry (Ci^sub); counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge adds slice k (bits [WIDTH-CHUNK*(k+1) : WIDTH-1-CHUNK*k], least significant slice first) plus the carry register.
  - Writes the slice result into S and updates the carry register.
  - After slice NCHUNK-1: Co and ovf are registered and the FSM goes to DONE.
- Latency: out_valid rises NCHUNK edges after the accepting edge (2 for 8/4).
- DONE:
  - out_valid=1; S, Co and ovf held stable; in_ready=0.
  - On out_ready: out_valid drops and the FSM returns to IDLE next edge.
  - in_valid during DONE is ignored (no overlap).
- Minimum issue interval: NCHUNK+2 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- S is not valid outside DONE; the bench samples it only when out_valid=1.
- Reset mid-RUN or mid-DONE aborts the operation: outputs go to reset values immediately and the result is lost.
- NCHUNK=1 is legal: a single RUN cycle.

Optional Feature:
Macro CHUNKED_SEQ_ADDER_ZERO_EN.
- Defined: adds output port Z (1 bit). Z is registered with Co and valid in DONE. Z=1 iff S==0. Z resets to 0. Z is computed by ANDing per-slice zero flags accumulated during RUN, not by a full-width compare.
- Undefined: no Z port and no extra logic; all other behaviour is identical.

Test Plan:
- WIDTH=8/CHUNK=4, add 0x7F+0x01, Ci=0 -> S=0x80, Co=0, ovf=1; out_valid exactly 2 cycles after acceptance.
- add 0xFF+0x01, Ci=0 -> S=0x00, Co=1, ovf=0; Z=1 when CHUNKED_SEQ_ADDER_ZERO_EN is defined.
- sub 0x05-0x07, Ci=0 -> S=0xFE, Co=0, ovf=0. Then sub 0x80-0x01, Ci=0 -> S=0x7F, Co=1, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, S, Co and ovf stable; in_ready=0; in_valid pulses ignored. Raising out_ready gives IDLE next cycle with in_ready=1.
- Assert rst_n=0 during RUN -> out_valid=0 and S=0 immediately. After release, 0x12+0x34 -> S=0x46, Co=0.
- WIDTH=16/CHUNK=4, add 0x1234+0xEDCB, Ci=1 -> S=0x0000, Co=1, ovf=0; latency 4 cycles.
